// File: rtl/fan_pkg.sv
// Shared constants for the fan motor controller: state encoding, speed levels
// and the width of every seconds value.
package fan_pkg;

    localparam int unsigned SEC_W = 5;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_TIMED  = 2'd2;
    localparam logic [1:0] ST_EXPIRE = 2'd3;

    localparam logic [1:0] SPEED_OFF = 2'd0;
    localparam logic [1:0] SPEED_1   = 2'd1;
    localparam logic [1:0] SPEED_2   = 2'd2;
    localparam logic [1:0] SPEED_3   = 2'd3;

    localparam logic [1:0] PRESET_NONE = 2'd0;

endpackage

// File: rtl/fan_timer_controller_preset_sel.sv
// Maps an auto-off preset index to its target time in seconds; index 0 is no timer.
module fan_timer_controller_preset_sel
    import fan_pkg::*;
#(
    parameter int unsigned T_PRESET1 = 5,
    parameter int unsigned T_PRESET2 = 10,
    parameter int unsigned T_PRESET3 = 15
) (
    input  logic [1:0]       preset_idx_i,
    output logic [SEC_W-1:0] preset_sec_c
);

    always_comb begin
        preset_sec_c = '0;
        case (preset_idx_i)
            2'd1:    preset_sec_c = SEC_W'(T_PRESET1);
            2'd2:    preset_sec_c = SEC_W'(T_PRESET2);
            2'd3:    preset_sec_c = SEC_W'(T_PRESET3);
            default: preset_sec_c = '0;
        endcase
    end

endmodule

// File: rtl/fan_timer_controller.sv
// Fan motor sequencer: button pulses -> motor enable, speed level and auto-off
// timer control of the external seconds counter.
module fan_timer_controller
    import fan_pkg::*;
#(
    parameter int unsigned T_PRESET1 = 5,
    parameter int unsigned T_PRESET2 = 10,
    parameter int unsigned T_PRESET3 = 15
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_power,
    input  logic             i_btn_speed,
    input  logic             i_btn_timer,
    input  logic [SEC_W-1:0] i_elapsed_sec,
    output logic             o_motor_en,
    output logic [1:0]       o_speed,
    output logic             o_timer_mode,
    output logic [SEC_W-1:0] o_time_state,
    output logic             o_counter_clr,
    output logic [SEC_W-1:0] o_remaining
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       speed_q, speed_d;
    logic [1:0]       idx_q, idx_d;
    logic [SEC_W-1:0] time_state_q, time_state_d;
    logic             timer_mode_q, timer_mode_d;
    logic             motor_en_q, motor_en_d;
    logic             counter_clr_q, counter_clr_d;
    logic             clr_prev_q;

    logic [1:0]       idx_inc_c;
    logic [1:0]       speed_next_c;
    logic [SEC_W-1:0] preset_sec_c;
    logic             expire_c;
    logic             clr_req_c;

    assign idx_inc_c    = idx_q + 2'd1;
    assign speed_next_c = (speed_q == SPEED_3) ? SPEED_1 : speed_q + 2'd1;

    fan_timer_controller_preset_sel #(
        .T_PRESET1 (T_PRESET1),
        .T_PRESET2 (T_PRESET2),
        .T_PRESET3 (T_PRESET3)
    ) u_preset_sel (
        .preset_idx_i (idx_inc_c),
        .preset_sec_c (preset_sec_c)
    );

    // A clear issued in this or the previous cycle may not yet be seen on the
    // elapsed count, so the comparison is held off for those two cycles.
    assign expire_c = (i_elapsed_sec >= time_state_q) && !counter_clr_q && !clr_prev_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_OFF;
            speed_q       <= SPEED_OFF;
            idx_q         <= PRESET_NONE;
            time_state_q  <= '0;
            timer_mode_q  <= 1'b0;
            motor_en_q    <= 1'b0;
            counter_clr_q <= 1'b0;
            clr_prev_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            speed_q       <= speed_d;
            idx_q         <= idx_d;
            time_state_q  <= time_state_d;
            timer_mode_q  <= timer_mode_d;
            motor_en_q    <= motor_en_d;
            counter_clr_q <= counter_clr_d;
            clr_prev_q    <= counter_clr_q;
        end
    end

    // Next-state and output logic; button priority is power > timer > speed.
    always_comb begin
        state_d      = state_q;
        speed_d      = speed_q;
        idx_d        = idx_q;
        time_state_d = time_state_q;
        timer_mode_d = timer_mode_q;
        motor_en_d   = motor_en_q;
        clr_req_c    = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (i_btn_power) begin
                    state_d      = ST_RUN;
                    speed_d      = SPEED_1;
                    idx_d        = PRESET_NONE;
                    motor_en_d   = 1'b1;
                    timer_mode_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_btn_power) begin
                    state_d      = ST_OFF;
                    speed_d      = SPEED_OFF;
                    idx_d        = PRESET_NONE;
                    motor_en_d   = 1'b0;
                    timer_mode_d = 1'b0;
                end else if (i_btn_timer) begin
                    state_d      = ST_TIMED;
                    idx_d        = idx_inc_c;
                    time_state_d = preset_sec_c;
                    timer_mode_d = 1'b1;
                    clr_req_c    = 1'b1;
                end else if (i_btn_speed) begin
                    speed_d = speed_next_c;
                end
            end
            ST_TIMED: begin
                if (i_btn_power) begin
                    state_d      = ST_OFF;
                    speed_d      = SPEED_OFF;
                    idx_d        = PRESET_NONE;
                    motor_en_d   = 1'b0;
                    timer_mode_d = 1'b0;
                    clr_req_c    = 1'b1;
                end else if (i_btn_timer) begin
                    idx_d = idx_inc_c;
                    if (idx_inc_c == PRESET_NONE) begin
                        state_d      = ST_RUN;
                        timer_mode_d = 1'b0;
                    end else begin
                        time_state_d = preset_sec_c;
                        clr_req_c    = 1'b1;
                    end
                end else if (expire_c) begin
                    state_d      = ST_EXPIRE;
                    motor_en_d   = 1'b0;
                    timer_mode_d = 1'b0;
                    clr_req_c    = 1'b1;
                end else if (i_btn_speed) begin
                    speed_d = speed_next_c;
                end
            end
            default: begin
                state_d      = ST_OFF;
                speed_d      = SPEED_OFF;
                idx_d        = PRESET_NONE;
                motor_en_d   = 1'b0;
                timer_mode_d = 1'b0;
            end
        endcase

        // Back-to-back requests collapse into a single clear pulse.
        counter_clr_d = clr_req_c && !counter_clr_q;
    end

    always_comb begin
        o_remaining = '0;
        if (state_q == ST_TIMED && i_elapsed_sec < time_state_q) begin
            o_remaining = time_state_q - i_elapsed_sec;
        end
    end

    assign o_motor_en    = motor_en_q;
    assign o_speed       = speed_q;
    assign o_timer_mode  = timer_mode_q;
    assign o_time_state  = time_state_q;
    assign o_counter_clr = counter_clr_q;

endmodule

// File: tb/tb_fan_timer_controller.sv
// Table-driven scoreboard bench for fan_timer_controller with hand-written
// asynchronous reset sequence.
module tb_fan_timer_controller;

    logic       clk;
    logic       rst;
    logic       btn_power, btn_speed, btn_timer;
    logic [4:0] elapsed;
    logic       motor_en, timer_mode, counter_clr;
    logic [1:0] speed;
    logic [4:0] time_state, remaining;

    fan_timer_controller #(
        .T_PRESET1 (5),
        .T_PRESET2 (10),
        .T_PRESET3 (15)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_btn_power   (btn_power),
        .i_btn_speed   (btn_speed),
        .i_btn_timer   (btn_timer),
        .i_elapsed_sec (elapsed),
        .o_motor_en    (motor_en),
        .o_speed       (speed),
        .o_timer_mode  (timer_mode),
        .o_time_state  (time_state),
        .o_counter_clr (counter_clr),
        .o_remaining   (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic       s;
        logic       t;
        logic [4:0] el;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        int          idx;
        logic [14:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [14:0] e(input logic me, input logic [1:0] sp, input logic tm,
                                      input logic [4:0] ts, input logic clr, input logic [4:0] rem);
        return {me, sp, tm, ts, clr, rem};
    endfunction

    function automatic vec_t r(input logic p, input logic s, input logic t,
                               input logic [4:0] el, input logic [14:0] exp);
        vec_t v;
        v.p = p; v.s = s; v.t = t; v.el = el; v.exp = exp;
        return v;
    endfunction

    function automatic logic [14:0] act();
        return {motor_en, speed, timer_mode, time_state, counter_clr, remaining};
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got me=%b sp=%0d tm=%b ts=%0d clr=%b rem=%0d, want me=%b sp=%0d tm=%b ts=%0d clr=%b rem=%0d",
                     name, got[14], got[13:12], got[11], got[10:6], got[5], got[4:0],
                     want[14], want[13:12], want[11], want[10:6], want[5], want[4:0]);
        end
    endtask

    task automatic pop_check();
        sb_t x;
        if (sb.size() == 0) return;
        x = sb.pop_front();
        check($sformatf("row%0d", x.idx), act(), x.exp);
    endtask

    initial begin
        // power then speed x3
        vecs.push_back(r(1,0,0, 0, e(1,1,0, 0,0,0)));
        vecs.push_back(r(0,1,0, 0, e(1,2,0, 0,0,0)));
        vecs.push_back(r(0,1,0, 0, e(1,3,0, 0,0,0)));
        vecs.push_back(r(0,1,0, 0, e(1,1,0, 0,0,0)));
        vecs.push_back(r(0,0,0, 0, e(1,1,0, 0,0,0)));
        // timer preset 5, count up to expiry
        vecs.push_back(r(0,0,1, 0, e(1,1,1, 5,1,5)));
        vecs.push_back(r(0,0,0, 0, e(1,1,1, 5,0,5)));
        vecs.push_back(r(0,0,0, 1, e(1,1,1, 5,0,4)));
        vecs.push_back(r(0,0,0, 2, e(1,1,1, 5,0,3)));
        vecs.push_back(r(0,0,0, 3, e(1,1,1, 5,0,2)));
        vecs.push_back(r(0,0,0, 4, e(1,1,1, 5,0,1)));
        vecs.push_back(r(0,0,0, 5, e(0,1,0, 5,1,0)));
        vecs.push_back(r(0,0,0, 5, e(0,0,0, 5,0,0)));
        // preset cycling 5 -> 10 -> 15 -> none -> 5
        vecs.push_back(r(1,0,0, 0, e(1,1,0, 5,0,0)));
        vecs.push_back(r(0,0,1, 0, e(1,1,1, 5,1,5)));
        vecs.push_back(r(0,0,0, 3, e(1,1,1, 5,0,2)));
        vecs.push_back(r(0,0,1, 3, e(1,1,1,10,1,7)));
        vecs.push_back(r(0,0,0, 0, e(1,1,1,10,0,10)));
        vecs.push_back(r(0,0,1, 0, e(1,1,1,15,1,15)));
        vecs.push_back(r(0,0,0, 0, e(1,1,1,15,0,15)));
        vecs.push_back(r(0,0,1, 0, e(1,1,0,15,0,0)));
        vecs.push_back(r(0,0,1, 0, e(1,1,1, 5,1,5)));
        vecs.push_back(r(0,0,0, 0, e(1,1,1, 5,0,5)));
        vecs.push_back(r(0,1,0, 0, e(1,2,1, 5,0,5)));
        // power off from TIMED clears counter; simultaneous buttons in RUN
        vecs.push_back(r(1,0,0, 0, e(0,0,0, 5,1,0)));
        vecs.push_back(r(1,0,0, 0, e(1,1,0, 5,0,0)));
        vecs.push_back(r(1,1,1, 0, e(0,0,0, 5,0,0)));
        vecs.push_back(r(0,1,0, 0, e(0,0,0, 5,0,0)));
        vecs.push_back(r(0,0,1, 0, e(0,0,0, 5,0,0)));
        // overshoot
        vecs.push_back(r(1,0,0, 0, e(1,1,0, 5,0,0)));
        vecs.push_back(r(0,0,1, 0, e(1,1,1, 5,1,5)));
        vecs.push_back(r(0,0,0, 0, e(1,1,1, 5,0,5)));
        vecs.push_back(r(0,0,0, 0, e(1,1,1, 5,0,5)));
        vecs.push_back(r(0,0,0, 9, e(0,1,0, 5,1,0)));
        vecs.push_back(r(0,0,0, 0, e(0,0,0, 5,0,0)));
        // expiry held off for two cycles after a clear; EXPIRE ignores power
        vecs.push_back(r(1,0,0, 0, e(1,1,0, 5,0,0)));
        vecs.push_back(r(0,0,1, 9, e(1,1,1, 5,1,0)));
        vecs.push_back(r(0,0,0, 9, e(1,1,1, 5,0,0)));
        vecs.push_back(r(0,0,0, 9, e(1,1,1, 5,0,0)));
        vecs.push_back(r(0,0,0, 9, e(0,1,0, 5,1,0)));
        vecs.push_back(r(1,0,0, 0, e(0,0,0, 5,0,0)));
        vecs.push_back(r(1,0,0, 0, e(1,1,0, 5,0,0)));
        // clear right after clear is suppressed
        vecs.push_back(r(0,0,1, 0, e(1,1,1, 5,1,5)));
        vecs.push_back(r(1,0,0, 0, e(0,0,0, 5,0,0)));
        // set up TIMED at preset 10, elapsed 7
        vecs.push_back(r(1,0,0, 0, e(1,1,0, 5,0,0)));
        vecs.push_back(r(0,0,1, 0, e(1,1,1, 5,1,5)));
        vecs.push_back(r(0,0,0, 0, e(1,1,1, 5,0,5)));
        vecs.push_back(r(0,0,1, 0, e(1,1,1,10,1,10)));
        vecs.push_back(r(0,0,0, 7, e(1,1,1,10,0,3)));

        rst = 1'b1;
        btn_power = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0;
        elapsed = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_values", act(), e(0,0,0,0,0,0));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            pop_check();
            btn_power = vecs[i].p;
            btn_speed = vecs[i].s;
            btn_timer = vecs[i].t;
            elapsed   = vecs[i].el;
            sb.push_back('{i, vecs[i].exp});
        end
        @(negedge clk);
        pop_check();

        // asynchronous reset mid-TIMED, between clock edges
        #2 rst = 1'b1;
        #1 check("async_reset", act(), e(0,0,0,0,0,0));
        @(negedge clk);
        check("reset_hold", act(), e(0,0,0,0,0,0));
        rst = 1'b0;
        elapsed = '0;
        @(negedge clk);
        btn_power = 1'b1;
        @(negedge clk);
        btn_power = 1'b0;
        check("after_reset_power", act(), e(1,1,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
